// File: rtl/fabric_mem_slave_if.sv
// Fabric request/response channel bundle for fabric_mem_slave.
// The master drives requests and rsp_ready; the slave drives req_ready
// and the response fields.
interface fabric_mem_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int OP_W   = 8,
    parameter int SIZE_W = 3,
    parameter int ATTR_W = 8,
    parameter int CODE_W = 8
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic [OP_W-1:0]       req_op;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wstrb;
    logic [SIZE_W-1:0]     req_size;
    logic [ATTR_W-1:0]     req_attr;
    logic [ID_W-1:0]       req_id;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic [CODE_W-1:0]     rsp_code;
    logic [ID_W-1:0]       rsp_id;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_wstrb,
               req_size, req_attr, req_id, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_code, rsp_id
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_wstrb,
               req_size, req_attr, req_id, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_code, rsp_id
    );
endinterface

// File: rtl/fabric_mem_slave.sv
// Fabric responder backed by a word-addressed scratchpad memory.
// Requests are decoded and executed on the accept edge; the resulting
// responses are queued in an in-order FIFO that absorbs rsp_ready
// backpressure. Memory contents are deliberately not reset.
module fabric_mem_slave #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int OP_W      = 8,
    parameter int SIZE_W    = 3,
    parameter int ATTR_W    = 8,
    parameter int CODE_W    = 8,
    parameter int MEM_WORDS = 256,
    parameter int RSP_DEPTH = 4,
    parameter logic [OP_W-1:0] OP_READ  = 8'h00,
    parameter logic [OP_W-1:0] OP_WRITE = 8'h01
) (
    input  logic               clk,
    input  logic               rst,
    fabric_mem_slave_if.slave  bus
);
    localparam int LANES   = DATA_W / 8;
    localparam int LANE_LG = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int MEM_AW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int PTR_W   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W   = $clog2(RSP_DEPTH + 1);

    localparam logic [CODE_W-1:0] CODE_OK       = 8'h00;
    localparam logic [CODE_W-1:0] CODE_BAD_OP   = 8'h01;
    localparam logic [CODE_W-1:0] CODE_RANGE    = 8'h02;
    localparam logic [CODE_W-1:0] CODE_MISALIGN = 8'h03;

    // Storage
    logic [DATA_W-1:0] mem_r [MEM_WORDS];

    logic [DATA_W-1:0] fifo_rdata_r [RSP_DEPTH];
    logic [CODE_W-1:0] fifo_code_r  [RSP_DEPTH];
    logic [ID_W-1:0]   fifo_id_r    [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    // Decode
    logic              push_s;
    logic              pop_s;
    logic              is_read_s;
    logic              is_write_s;
    logic              size_big_s;
    logic [ADDR_W-1:0] align_mask_s;
    logic              misalign_s;
    logic [ADDR_W-1:0] word_idx_s;
    logic              range_err_s;
    logic [MEM_AW-1:0] mem_idx_s;
    logic [CODE_W-1:0] code_s;
    logic [DATA_W-1:0] rdata_s;
    logic              mem_we_s;
    logic              unused_s;

    // Ready depends on reset and FIFO occupancy only.
    assign bus.req_ready = !rst && (count_r < CNT_W'(RSP_DEPTH));
    assign push_s        = bus.req_valid && bus.req_ready;
    assign pop_s         = bus.rsp_valid && bus.rsp_ready;

    assign bus.rsp_valid = (count_r != {CNT_W{1'b0}});
    assign bus.rsp_rdata = fifo_rdata_r[rd_ptr_r];
    assign bus.rsp_code  = fifo_code_r[rd_ptr_r];
    assign bus.rsp_id    = fifo_id_r[rd_ptr_r];

    // Attributes carry no meaning for this endpoint.
    assign unused_s = ^bus.req_attr;

    // Request decode: bad op beats misaligned beats out of range.
    always_comb begin
        is_read_s    = (bus.req_op == OP_READ);
        is_write_s   = (bus.req_op == OP_WRITE);
        size_big_s   = (bus.req_size > SIZE_W'(LANE_LG));
        align_mask_s = (ADDR_W'(1) << bus.req_size) - ADDR_W'(1);
        misalign_s   = size_big_s || ((bus.req_addr & align_mask_s) != {ADDR_W{1'b0}});
        word_idx_s   = bus.req_addr >> LANE_LG;
        range_err_s  = (word_idx_s >= ADDR_W'(MEM_WORDS));
        mem_idx_s    = word_idx_s[MEM_AW-1:0];
        code_s       = CODE_OK;
        rdata_s      = {DATA_W{1'b0}};
        mem_we_s     = 1'b0;
        if (!is_read_s && !is_write_s) begin
            code_s = CODE_BAD_OP;
        end else if (misalign_s) begin
            code_s = CODE_MISALIGN;
        end else if (range_err_s) begin
            code_s = CODE_RANGE;
        end else if (is_read_s) begin
            rdata_s = mem_r[mem_idx_s];
        end else begin
            mem_we_s = 1'b1;
        end
    end

    // Byte-lane memory write on an accepted OK write; contents survive reset.
    always_ff @(posedge clk) begin
        if (push_s && mem_we_s) begin
            for (int l = 0; l < LANES; l++) begin
                if (bus.req_wstrb[l]) begin
                    mem_r[mem_idx_s][8*l +: 8] <= bus.req_wdata[8*l +: 8];
                end
            end
        end
    end

    // Response FIFO: enqueue on accept, dequeue on response handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_rdata_r[i] <= {DATA_W{1'b0}};
                fifo_code_r[i]  <= {CODE_W{1'b0}};
                fifo_id_r[i]    <= {ID_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                fifo_rdata_r[wr_ptr_r] <= rdata_s;
                fifo_code_r[wr_ptr_r]  <= code_s;
                fifo_id_r[wr_ptr_r]    <= bus.req_id;
                wr_ptr_r <= (wr_ptr_r == PTR_W'(RSP_DEPTH - 1)) ? {PTR_W{1'b0}}
                                                                : wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_W'(RSP_DEPTH - 1)) ? {PTR_W{1'b0}}
                                                                : rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: tb/tb_fabric_mem_slave.sv
// Directed self-checking bench for fabric_mem_slave.
module tb_fabric_mem_slave;
    logic clk;
    logic rst;
    int   tests;
    int   failed;

    fabric_mem_slave_if bus ();

    fabric_mem_slave dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overall time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           input logic [2:0] size, input logic [3:0] id);
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wstrb = wstrb;
        bus.req_size  = size;
        bus.req_id    = id;
        bus.req_attr  = 8'h5A;
    endtask

    // Single request with rsp_ready high: response must appear one cycle
    // after the accept and be gone one cycle later.
    task automatic do_req(input string tag, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input logic [2:0] size, input logic [3:0] id,
                          input logic [31:0] exp_rdata, input logic [7:0] exp_code);
        bus.rsp_ready = 1'b1;
        check({tag, ".ready"}, {31'd0, bus.req_ready}, 32'd1);
        set_req(op, addr, wdata, wstrb, size, id);
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check({tag, ".valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        check({tag, ".rdata"}, bus.rsp_rdata, exp_rdata);
        check({tag, ".code"}, {24'd0, bus.rsp_code}, {24'd0, exp_code});
        check({tag, ".id"}, {28'd0, bus.rsp_id}, {28'd0, id});
        @(negedge clk);
        check({tag, ".drained"}, {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        tests = 0;
        failed = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        set_req(8'h00, 32'h0, 32'h0, 4'h0, 3'd2, 4'h0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst.req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst.rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst.rsp_code", {24'd0, bus.rsp_code}, 32'd0);
        check("rst.rsp_id", {28'd0, bus.rsp_id}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic write / read
        do_req("wr10", 8'h01, 32'h10, 32'hDEADBEEF, 4'hF, 3'd2, 4'd3, 32'h0, 8'h00);
        do_req("rd10", 8'h00, 32'h10, 32'h0, 4'h0, 3'd2, 4'd5, 32'hDEADBEEF, 8'h00);

        // Byte write into lane 1
        do_req("wrb11", 8'h01, 32'h11, 32'h0000AA00, 4'h2, 3'd0, 4'd1, 32'h0, 8'h00);
        do_req("rd10b", 8'h00, 32'h10, 32'h0, 4'h0, 3'd2, 4'd2, 32'hDEADAAEF, 8'h00);

        // Word 0 seeded to detect aliasing of out-of-range writes
        do_req("wr00", 8'h01, 32'h00, 32'hCAFEF00D, 4'hF, 3'd2, 4'd6, 32'h0, 8'h00);

        // Error cases
        do_req("badop", 8'h07, 32'h10, 32'h12345678, 4'hF, 3'd2, 4'd7, 32'h0, 8'h01);
        do_req("misal", 8'h01, 32'h12, 32'h11111111, 4'hF, 3'd2, 4'd8, 32'h0, 8'h03);
        do_req("size8", 8'h01, 32'h10, 32'h22222222, 4'hF, 3'd3, 4'd9, 32'h0, 8'h03);
        do_req("range", 8'h01, 32'h400, 32'h33333333, 4'hF, 3'd2, 4'd10, 32'h0, 8'h02);
        do_req("rdrange", 8'h00, 32'h400, 32'h0, 4'h0, 3'd2, 4'd11, 32'h0, 8'h02);
        do_req("pri_op", 8'h07, 32'h402, 32'h0, 4'h0, 3'd2, 4'd12, 32'h0, 8'h01);
        do_req("pri_mis", 8'h00, 32'h402, 32'h0, 4'h0, 3'd2, 4'd13, 32'h0, 8'h03);
        do_req("rd10c", 8'h00, 32'h10, 32'h0, 4'h0, 3'd2, 4'd14, 32'hDEADAAEF, 8'h00);
        do_req("rd00", 8'h00, 32'h00, 32'h0, 4'h0, 3'd2, 4'd15, 32'hCAFEF00D, 8'h00);

        // Backpressure: four accepts fill the FIFO
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp.ready%0d", i), {31'd0, bus.req_ready}, 32'd1);
            set_req(8'h00, 32'h10, 32'h0, 4'h0, 3'd2, 4'(i));
            bus.req_valid = 1'b1;
            @(negedge clk);
        end
        set_req(8'h00, 32'h10, 32'h0, 4'h0, 3'd2, 4'd4);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp.full%0d", c), {31'd0, bus.req_ready}, 32'd0);
            check($sformatf("bp.valid%0d", c), {31'd0, bus.rsp_valid}, 32'd1);
            check($sformatf("bp.id%0d", c), {28'd0, bus.rsp_id}, 32'd0);
            check($sformatf("bp.data%0d", c), bus.rsp_rdata, 32'hDEADAAEF);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp.pop_id1", {28'd0, bus.rsp_id}, 32'd1);
        check("bp.ready_after_pop", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        check("bp.id2", {28'd0, bus.rsp_id}, 32'd2);
        set_req(8'h00, 32'h10, 32'h0, 4'h0, 3'd2, 4'd5);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("bp.id3", {28'd0, bus.rsp_id}, 32'd3);
        @(negedge clk);
        check("bp.id4", {28'd0, bus.rsp_id}, 32'd4);
        @(negedge clk);
        check("bp.id5", {28'd0, bus.rsp_id}, 32'd5);
        check("bp.data5", bus.rsp_rdata, 32'hDEADAAEF);
        @(negedge clk);
        check("bp.empty", {31'd0, bus.rsp_valid}, 32'd0);

        // Reset with three queued responses; memory must survive
        do_req("wr20", 8'h01, 32'h20, 32'h55AA55AA, 4'hF, 3'd2, 4'd1, 32'h0, 8'h00);
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(8'h00, 32'h20, 32'h0, 4'h0, 3'd2, 4'(7 + i));
            bus.req_valid = 1'b1;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        check("rq.valid_before", {31'd0, bus.rsp_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rq.async_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rq.async_ready", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rq.ready_after", {31'd0, bus.req_ready}, 32'd1);
        check("rq.empty_after", {31'd0, bus.rsp_valid}, 32'd0);
        do_req("rd20", 8'h00, 32'h20, 32'h0, 4'h0, 3'd2, 4'd2, 32'h55AA55AA, 8'h00);
        do_req("rd10d", 8'h00, 32'h10, 32'h0, 4'h0, 3'd2, 4'd3, 32'hDEADAAEF, 8'h00);

        // Streaming: alternating write/read per word, one accept per cycle
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 33; k++) begin
            if (k > 0) begin
                check($sformatf("st.valid%0d", k - 1), {31'd0, bus.rsp_valid}, 32'd1);
                check($sformatf("st.code%0d", k - 1), {24'd0, bus.rsp_code}, 32'd0);
                check($sformatf("st.id%0d", k - 1), {28'd0, bus.rsp_id}, {28'd0, 4'(k - 1)});
                check($sformatf("st.data%0d", k - 1), bus.rsp_rdata,
                      ((k - 1) % 2 == 1) ? (32'h12340000 + 32'((k - 1) / 2)) : 32'h0);
            end
            if (k < 32) begin
                check($sformatf("st.ready%0d", k), {31'd0, bus.req_ready}, 32'd1);
                set_req((k % 2 == 0) ? 8'h01 : 8'h00, 32'h100 + 32'(4 * (k / 2)),
                        32'h12340000 + 32'(k / 2), 4'hF, 3'd2, 4'(k));
                bus.req_valid = 1'b1;
            end else begin
                bus.req_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("st.drained", {31'd0, bus.rsp_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/fabric_mem_slave.md
Name: fabric_mem_slave

Overview:
- Fabric responder (slave end of the ready/valid request+response fabric channel) backed by a small word-addressed internal memory.
- Accepts read/write requests, checks op/size/alignment/range, and performs the memory access at the accept edge.
- Queues the resulting responses in an in-order response FIFO that absorbs rsp_ready backpressure.
- Used as a scratchpad/boot RAM endpoint and as the reference responder in fabric benches; ports map 1:1 onto the fabric_if slave modport.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 32, data width; multiple of 8; DATA_W/8 a power of two.
- ID_W, 4, request/response ID width.
- OP_W, 8, opcode width.
- SIZE_W, 3, size field width (transfer = 2^req_size bytes).
- ATTR_W, 8, attribute width; attributes are ignored.
- CODE_W, 8, response code width.
- MEM_WORDS, 256, memory depth in DATA_W words.
- RSP_DEPTH, 4, response FIFO entries (>=1).
- OP_READ, 8'h00, read opcode.
- OP_WRITE, 8'h01, write opcode.

Ports:
- clk in 1: clock.
- rst in 1: reset, asynchronous, active-high.
- req_valid in 1: request valid.
- req_ready out 1: request accepted when req_valid && req_ready.
- req_op in OP_W: opcode.
- req_addr in ADDR_W: byte address.
- req_wdata in DATA_W: write data.
- req_wstrb in DATA_W/8: byte-lane write enables.
- req_size in SIZE_W: log2 transfer bytes.
- req_attr in ATTR_W: ignored.
- req_id in ID_W: transaction ID.
- rsp_valid out 1: response valid.
- rsp_ready in 1: response consumed when rsp_valid && rsp_ready.
- rsp_rdata out DATA_W: read data; 0 for writes and errors.
- rsp_code out CODE_W: 0x00 OK, 0x01 bad op, 0x02 out of range, 0x03 misaligned.
- rsp_id out ID_W: echoes req_id.

Behaviour:
- Reset (async assert, sync release): FIFO count/pointers=0; rsp_valid=0; rsp_rdata/code/id=0; req_ready=0 while rst high. Memory contents are not reset and survive reset. Reset mid-operation discards all queued responses.
- req_ready = !rst && (count < RSP_DEPTH). It is a function of state only: no combinational path from rsp_ready or req_* to req_ready.
- Decode on accept, with priority bad op > misaligned > out of range:
  - op not in {OP_READ, OP_WRITE} -> 0x01.
  - 2^req_size > DATA_W/8, or req_addr not a multiple of 2^req_size -> 0x03.
  - word index = req_addr >> log2(DATA_W/8); index >= MEM_WORDS -> 0x02.
- OK write: at the accept edge, each byte lane with wstrb set is written. Lanes are not additionally masked by size/offset. rdata=0.
- OK read: rdata = full word mem[index] sampled at the accept edge. Sub-word reads return the full word; the master extracts lanes.
- Error: no memory update; rdata=0.
- Response entry {rdata, code, id} is enqueued at the accept edge. A request accepted in cycle T gives rsp_valid at T+1 if the FIFO was empty. Minimum latency is 1 cycle; throughput is 1 request/cycle while rsp_ready=1.
- rsp_* driven from the FIFO head (registered). Stable while rsp_valid && !rsp_ready. Pop on rsp_valid && rsp_ready.
- Responses are strictly in acceptance order regardless of ID.
- Simultaneous push and pop: count unchanged; pointers wrap modulo RSP_DEPTH.
- Full (count == RSP_DEPTH): req_ready=0. A pop in that cycle raises req_ready in the next cycle only.
- Write followed by read to the same word on consecutive accepts: the read returns the new data.
- Request fields are only sampled on the accept edge; held requests while req_ready=0 have no effect.

Test Plan:
- Reset then write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, id 3; then read 0x10 id 5 -> rsp (0, 0x00, 3) then (0xDEADBEEF, 0x00, 5); each rsp_valid one cycle after its accept.
- Byte write addr 0x11, wstrb 0x2, wdata 0x0000AA00, size 0 over 0xDEADBEEF; read 0x10 -> 0xDEADAAEF.
- Error cases, each returning rdata 0 with no memory change:
  - op 0x07 -> 0x01.
  - addr 0x12 size 2 -> 0x03.
  - addr 0x400 (MEM_WORDS=256) -> 0x02.
- Hold rsp_ready=0, issue back-to-back reads ids 0..5 -> exactly 4 accepted, req_ready=0 after the 4th, rsp fields stable. Then rsp_ready=1 -> ids 0,1,2,3 in order; ids 4,5 accepted after space frees.
- Assert rst with 3 responses queued -> rsp_valid=0 and req_ready=0 immediately (async). After release, a read of the previously written word returns the old data.
- Streaming: rsp_ready=1, 16 alternating write/read to 16 words -> one accept per cycle, no stalls, all codes 0x00, data matches.
